// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit framer: FSM encoding, framing octets, CRC-32 constants.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SFD  = 3'd2,
    DATA = 3'd3,
    PAD  = 3'd4,
    FCS  = 3'd5,
    DROP = 3'd6,
    IFG  = 3'd7
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_OCTET = 8'h55;
  localparam logic [7:0]  SFD_OCTET      = 8'hD5;
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB20E3;
  localparam int          CNT_W          = 11;

  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-octet step of the reflected CRC-32; purely combinational, the caller owns the register.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Wraps an AXI-Stream payload into an Ethernet frame (preamble, SFD, pad, FCS, IFG) at one octet per strobe.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter bit PAD_EN    = 1'b1,
  parameter int IFG_BEATS = 12,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       tx_busy,
  output logic       tx_underrun
);

  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME);
  localparam logic [7:0]       IFG_LAST = 8'(IFG_BEATS - 1);
  localparam logic [7:0]       PRE_LAST = 8'd5;

  tx_state_e        state, state_nx;
  logic [7:0]       oct_q, oct_nx;
  logic             vld_q, vld_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_inc;
  logic [7:0]       beat_q, beat_nx;
  logic             bad_q, bad_nx;
  logic             und_nx;
  logic [31:0]      crc_q, crc_upd, fcs_word;
  logic [7:0]       crc_din, fcs_oct;
  logic             crc_clr, crc_en, go;

  crc32_d8 u_crc (.crc(crc_q), .data(crc_din), .crc_next(crc_upd));

  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  // An aborted frame sends the raw register, i.e. the complement of the good FCS.
  assign fcs_word = bad_q ? crc_q : ~crc_q;
  assign fcs_oct  = fcs_word[{beat_q[1:0], 3'b000} +: 8];

  // State names the source of the octet loaded on the next strobe; the loaded octet is on the wire after it.
  always_comb begin
    state_nx = state;
    oct_nx   = oct_q;
    vld_nx   = vld_q;
    cnt_nx   = cnt_q;
    beat_nx  = beat_q;
    bad_nx   = bad_q;
    und_nx   = 1'b0;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    crc_din  = 8'h00;
    s_tready = 1'b0;
    go       = 1'b0;
    unique case (state)
      IDLE: go = s_tvalid;
      PRE: if (m_tready) begin
        if (beat_q == PRE_LAST) begin
          state_nx = SFD;
          beat_nx  = '0;
        end else begin
          beat_nx = beat_q + 1'b1;
        end
      end
      SFD: if (m_tready) begin
        oct_nx   = SFD_OCTET;
        state_nx = DATA;
      end
      DATA: begin
        s_tready = m_tready;
        if (m_tready) begin
          if (s_tvalid) begin
            oct_nx  = s_tdata;
            crc_en  = 1'b1;
            crc_din = s_tdata;
            cnt_nx  = cnt_inc;
            if (s_tlast) begin
              state_nx = (PAD_EN && (cnt_inc < MIN_CNT)) ? PAD : FCS;
              beat_nx  = '0;
              bad_nx   = 1'b0;
            end
          end else begin
            und_nx   = 1'b1;
            oct_nx   = crc_q[7:0];
            bad_nx   = 1'b1;
            beat_nx  = 8'd1;
            state_nx = FCS;
          end
        end
      end
      PAD: if (m_tready) begin
        oct_nx = 8'h00;
        crc_en = 1'b1;
        cnt_nx = cnt_inc;
        if (cnt_inc >= MIN_CNT) begin
          state_nx = FCS;
          beat_nx  = '0;
        end
      end
      FCS: if (m_tready) begin
        if (beat_q == 8'd4) begin
          vld_nx   = 1'b0;
          oct_nx   = 8'h00;
          beat_nx  = '0;
          state_nx = bad_q ? DROP : IFG;
        end else begin
          oct_nx  = fcs_oct;
          beat_nx = beat_q + 1'b1;
        end
      end
      DROP: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          state_nx = IFG;
          beat_nx  = '0;
        end
      end
      IFG: if (m_tready) begin
        if (beat_q == IFG_LAST) begin
          // Chain straight into the next preamble so the gap never grows past IFG_BEATS.
          go       = s_tvalid;
          state_nx = IDLE;
        end else begin
          beat_nx = beat_q + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (go) begin
      state_nx = PRE;
      oct_nx   = PREAMBLE_OCTET;
      vld_nx   = 1'b1;
      cnt_nx   = '0;
      beat_nx  = '0;
      bad_nx   = 1'b0;
      crc_clr  = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state       <= IDLE;
      oct_q       <= 8'h00;
      vld_q       <= 1'b0;
      cnt_q       <= '0;
      beat_q      <= '0;
      bad_q       <= 1'b0;
      tx_underrun <= 1'b0;
      crc_q       <= CRC_INIT;
    end else begin
      state       <= state_nx;
      oct_q       <= oct_nx;
      vld_q       <= vld_nx;
      cnt_q       <= cnt_nx;
      beat_q      <= beat_nx;
      bad_q       <= bad_nx;
      tx_underrun <= und_nx;
      crc_q       <= crc_clr ? CRC_INIT : (crc_en ? crc_upd : crc_q);
    end
  end

  assign m_tvalid = vld_q;
  assign m_tdata  = MSB_FIRST ? bitrev8(oct_q) : oct_q;
  assign tx_busy  = (state != IDLE);

endmodule
